noc_output_arbiter: RTL
=======================

NOC_OUTPUT_ARBITER -- requirements
Module: noc_output_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 5, meaning number of router input ports competing for this output.
REQ-002 SHALL have parameter FLIT_BUFFER_DEPTH, default 8, meaning downstream flit buffer depth and initial credit count.
REQ-003 SHALL have port clk_noc  input  1  NoC clock; single clock domain.
REQ-004 SHALL have port rst_noc_sync  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  NUM_INPUTS  per-input flit-valid request targeting this output.
REQ-006 SHALL have port is_tail  input  NUM_INPUTS  per-input tail marker of the presented flit.
REQ-007 SHALL have port credit_in  input  1  one credit returned by downstream per cycle when high.
REQ-008 SHALL have port grant  output  NUM_INPUTS  one-hot current owner; all-zero when unlocked.
REQ-009 SHALL have port send_out  output  1  flit of owner transferred this cycle.
REQ-010 SHALL have port credit_cnt  output  $clog2(FLIT_BUFFER_DEPTH+1)  current downstream credits.
REQ-011 SHALL have port credit_err  output  1  sticky credit-overflow flag.

Function
REQ-012 SHALL implement two states: IDLE (no owner) and LOCKED (owner held, wormhole).
REQ-013 In IDLE with any req bit set, SHALL select winner round-robin, searching from last_winner+1 upward with wrap at NUM_INPUTS-1 -> 0, and register grant; LOCKED next cycle.
REQ-014 In IDLE, send_out SHALL be 0; minimum one-cycle bubble between packets.
REQ-015 In LOCKED, send_out SHALL be combinationally req[owner] AND credit_cnt>0.
REQ-016 Fire (send_out=1) with is_tail[owner]=1 SHALL return to IDLE next cycle, clear grant, set last_winner=owner.
REQ-017 Owner dropping req in LOCKED SHALL NOT release the lock; other requests are ignored until owner's tail fires.
REQ-018 Credit update: fire only -> -1; credit_in only -> +1; both same cycle -> unchanged.
REQ-019 credit_in with credit_cnt==FLIT_BUFFER_DEPTH and no fire SHALL saturate credit_cnt and set credit_err until reset.
REQ-020 credit_cnt==0 SHALL block send_out; a credit_in that cycle takes effect next cycle.
REQ-021 Single-flit packet (head is tail) SHALL fire once in LOCKED and return to IDLE.
REQ-022 grant SHALL be strictly one-hot or zero in every cycle.

Reset
REQ-023 While rst_noc_sync high at clk_noc edge: state=IDLE, grant=0, send_out=0, last_winner=NUM_INPUTS-1 (input 0 wins first), credit_cnt=FLIT_BUFFER_DEPTH, credit_err=0.
REQ-024 Reset asserted mid-packet SHALL abandon the lock and restore full credits; no flit fires in the reset cycle.

Configuration
REQ-025 Macro NOC_ARB_TURN_MASK_EN defined: SHALL add port disable_turn input NUM_INPUTS; req bits with disable_turn set are masked before arbitration and never granted; masking a current owner mid-packet SHALL NOT release the lock.
REQ-026 Macro undefined: no disable_turn port; all requests eligible.

Structure
REQ-027 Package noc_arb_pkg SHALL hold the state enum (ARB_IDLE, ARB_LOCKED) and a credit-width function clog2(depth+1).
REQ-028 Round-robin search SHALL be a combinational sub-module rr_priority_picker (inputs: masked req, last_winner; outputs: one-hot pick, valid).

Verification
REQ-029 Reset, then req=5'b00110, tails=1 -> grant 5'b00010 cycle 1, send_out cycle 1; next packet grants 5'b00100.
REQ-030 All 5 inputs requesting single-flit packets continuously -> grant order 0,1,2,3,4,0; one fire every 2 cycles.
REQ-031 Input 2 sends 4-flit packet, credit_in held low, depth 8 -> credit_cnt 8->4; input 3 request ignored until tail fires.
REQ-032 credit_cnt driven to 0 mid-packet -> send_out 0 and grant held; single credit_in -> exactly one fire next cycle.
REQ-033 credit_in pulsed at credit_cnt=8 with no traffic -> credit_cnt stays 8, credit_err=1 until reset.
REQ-034 With NOC_ARB_TURN_MASK_EN, disable_turn=5'b00001, req=5'b00011 -> only input 1 ever granted.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// rtl/noc_arb_pkg.sv - shared types and width helpers for the NoC output arbiter
package noc_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Credit counter must hold every value 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_output_arbiter_if.sv
// rtl/noc_output_arbiter_if.sv - request/grant/credit bundle between router inputs and the output arbiter
interface noc_output_arbiter_if #(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 8
);
  localparam int CW = noc_arb_pkg::credit_width(FLIT_BUFFER_DEPTH);

  logic [NUM_INPUTS-1:0] req;
  logic [NUM_INPUTS-1:0] is_tail;
  logic                  credit_in;
  logic [NUM_INPUTS-1:0] grant;
  logic                  send_out;
  logic [CW-1:0]         credit_cnt;
  logic                  credit_err;

  modport master (
    output req, is_tail, credit_in,
    input  grant, send_out, credit_cnt, credit_err
  );

  modport slave (
    input  req, is_tail, credit_in,
    output grant, send_out, credit_cnt, credit_err
  );

endinterface

// File: rtl/noc_output_arbiter_picker.sv
// rtl/noc_output_arbiter_picker.sv - combinational round-robin picker searching upward from last_winner+1
module rr_priority_picker #(
  parameter int NUM_INPUTS = 5,
  parameter int IDX_W      = 3
) (
  input  logic [NUM_INPUTS-1:0] i_req,
  input  logic [IDX_W-1:0]      i_last_winner,
  output logic [NUM_INPUTS-1:0] o_pick,
  output logic                  o_valid
);

  logic [IDX_W-1:0] w_idx;

  // Offset NUM_INPUTS wraps back to last_winner itself, so it has lowest priority.
  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int off = 1; off <= NUM_INPUTS; off++) begin
      w_idx = IDX_W'((int'(i_last_winner) + off) % NUM_INPUTS);
      if (!o_valid && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        o_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - wormhole output arbiter with round-robin grant and downstream credits
// Optional turn masking (disable_turn port) is enabled by defining NOC_ARB_TURN_MASK_EN.
module noc_output_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 8
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc_sync,
  noc_output_arbiter_if.slave   bus
`ifdef NOC_ARB_TURN_MASK_EN
  ,
  input  logic [NUM_INPUTS-1:0] disable_turn
`endif
);

  localparam int CW = credit_width(FLIT_BUFFER_DEPTH);
  localparam int IW = index_width(NUM_INPUTS);
  localparam logic [CW-1:0] FULL_CREDITS = CW'(FLIT_BUFFER_DEPTH);
  localparam logic [IW-1:0] LAST_INPUT   = IW'(NUM_INPUTS - 1);

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  logic [NUM_INPUTS-1:0] r_grant;
  logic [NUM_INPUTS-1:0] w_grant_next;
  logic [IW-1:0]         r_owner;
  logic [IW-1:0]         w_owner_next;
  logic [IW-1:0]         r_last_winner;
  logic [IW-1:0]         w_last_winner_next;
  logic [CW-1:0]         r_credit_cnt;
  logic                  r_credit_err;

  logic [NUM_INPUTS-1:0] w_eligible;
  logic [NUM_INPUTS-1:0] w_pick;
  logic                  w_pick_valid;
  logic [IW-1:0]         w_pick_idx;
  logic                  w_owner_req;
  logic                  w_owner_tail;
  logic                  w_has_credit;
  logic                  w_fire;

  // Masking only gates new arbitration; an owner is tracked through r_grant regardless.
`ifdef NOC_ARB_TURN_MASK_EN
  assign w_eligible = bus.req & ~disable_turn;
`else
  assign w_eligible = bus.req;
`endif

  rr_priority_picker #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (IW)
  ) u_picker (
    .i_req         (w_eligible),
    .i_last_winner (r_last_winner),
    .o_pick        (w_pick),
    .o_valid       (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (w_pick[i]) begin
        w_pick_idx = IW'(i);
      end
    end
  end

  assign w_owner_req  = |(bus.req & r_grant);
  assign w_owner_tail = |(bus.is_tail & r_grant);
  assign w_has_credit = (r_credit_cnt != '0);
  assign w_fire       = (r_state == ARB_LOCKED) && w_owner_req && w_has_credit && !rst_noc_sync;

  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_owner_next       = r_owner;
    w_last_winner_next = r_last_winner;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          w_state_next = ARB_LOCKED;
          w_grant_next = w_pick;
          w_owner_next = w_pick_idx;
        end
      end
      ARB_LOCKED: begin
        if (w_fire && w_owner_tail) begin
          w_state_next       = ARB_IDLE;
          w_grant_next       = '0;
          w_last_winner_next = r_owner;
        end
      end
      default: begin
        w_state_next = ARB_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      r_state       <= ARB_IDLE;
      r_grant       <= '0;
      r_owner       <= '0;
      r_last_winner <= LAST_INPUT;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_owner       <= w_owner_next;
      r_last_winner <= w_last_winner_next;
    end
  end

  // A simultaneous fire and credit return cancel out; a return at full credit is an overflow.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      r_credit_cnt <= FULL_CREDITS;
      r_credit_err <= 1'b0;
    end else begin
      case ({w_fire, bus.credit_in})
        2'b10: r_credit_cnt <= r_credit_cnt - CW'(1);
        2'b01: begin
          if (r_credit_cnt == FULL_CREDITS) begin
            r_credit_err <= 1'b1;
          end else begin
            r_credit_cnt <= r_credit_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.grant      = r_grant;
  assign bus.send_out   = w_fire;
  assign bus.credit_cnt = r_credit_cnt;
  assign bus.credit_err = r_credit_err;

endmodule
